// File: rtl/hog_pkg.sv
// hog_pkg: shared HOG pipeline defaults, counter widths and window index helpers
package hog_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_KERNEL_WIDTH = 3;
  localparam int DEF_IMG_WIDTH = 854;
  localparam int DEF_IMG_HEIGHT = 480;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int COL_CNT_W = cnt_w(DEF_IMG_WIDTH);
  localparam int ROW_CNT_W = cnt_w(DEF_IMG_HEIGHT - DEF_KERNEL_WIDTH + 1);
  function automatic int pix_lsb(input int row, input int col, input int k, input int dw);
    return (row * k + col) * dw;
  endfunction
  function automatic int col_lsb(input int row, input int dw);
    return row * dw;
  endfunction
endpackage

// File: rtl/window_gen_if.sv
// window_gen_if: column-in / window-out handshake bundle; master = upstream+downstream side, slave = window_gen
interface window_gen_if import hog_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KERNEL_WIDTH = DEF_KERNEL_WIDTH
) ();
  logic [KERNEL_WIDTH*DATA_WIDTH-1:0] col_data;
  logic col_valid;
  logic col_ready;
  logic [KERNEL_WIDTH*KERNEL_WIDTH*DATA_WIDTH-1:0] win_data;
  logic win_valid;
  logic win_ready;
  logic border_flag;
  logic win_last;
  modport master (
    output col_data, col_valid, win_ready,
    input col_ready, win_data, win_valid, border_flag, win_last
  );
  modport slave (
    input col_data, col_valid, win_ready,
    output col_ready, win_data, win_valid, border_flag, win_last
  );
endinterface

// File: rtl/window_pos_counter.sv
// window_pos_counter: col/row position of each accepted column (ports clk, rst, adv in; is_border, is_last out)
module window_pos_counter import hog_pkg::*; #(
  parameter int IMG_WIDTH = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int KERNEL_WIDTH = DEF_KERNEL_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic adv,
  output logic is_border,
  output logic is_last
);
  localparam int ROWS = IMG_HEIGHT - KERNEL_WIDTH + 1;
  localparam int CW = cnt_w(IMG_WIDTH);
  localparam int RW = cnt_w(ROWS);
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic col_end, row_end;
  assign col_end = col_cnt == CW'(IMG_WIDTH - 1);
  assign row_end = row_cnt == RW'(ROWS - 1);
  assign is_border = col_cnt < CW'(KERNEL_WIDTH - 1);
  assign is_last = col_end && row_end;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (adv) begin
      col_cnt <= col_end ? '0 : col_cnt + 1'b1;
      if (col_end) row_cnt <= row_end ? '0 : row_cnt + 1'b1;
    end
endmodule

// File: rtl/window_gen.sv
// window_gen: KxK sliding window with one-deep output slice (ports clk, rst, bus slave); WINDOW_BORDER_SKIP_EN drops border windows
module window_gen import hog_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int KERNEL_WIDTH = DEF_KERNEL_WIDTH
) (
  input logic clk,
  input logic rst,
  window_gen_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int K = KERNEL_WIDTH;
  localparam int RW = K * DW;
  logic [K*RW-1:0] win_q, win_d;
  logic win_valid, border_flag, win_last;
  logic col_ready, accept, is_border, is_last, keep_win, border_d;
  assign col_ready = !win_valid || bus.win_ready;
  assign accept = bus.col_valid && col_ready;
  window_pos_counter #(
    .IMG_WIDTH(IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .KERNEL_WIDTH(KERNEL_WIDTH)
  ) u_pos (
    .clk(clk),
    .rst(rst),
    .adv(accept),
    .is_border(is_border),
    .is_last(is_last)
  );
`ifdef WINDOW_BORDER_SKIP_EN
  assign keep_win = !is_border;
  assign border_d = 1'b0;
`else
  assign keep_win = 1'b1;
  assign border_d = is_border;
`endif
  always_comb begin
    win_d = win_q;
    for (int i = 0; i < K; i++)
      win_d[i*RW +: RW] = {bus.col_data[col_lsb(i, DW) +: DW], win_q[i*RW+DW +: RW-DW]};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      win_q <= '0;
      win_valid <= 1'b0;
      border_flag <= 1'b0;
      win_last <= 1'b0;
    end else if (accept) begin
      win_q <= win_d;
      win_valid <= keep_win;
      border_flag <= border_d;
      win_last <= is_last;
    end else if (bus.win_ready) begin
      win_valid <= 1'b0;
    end
  assign bus.col_ready = col_ready;
  assign bus.win_data = win_q;
  assign bus.win_valid = win_valid;
  assign bus.border_flag = border_flag;
  assign bus.win_last = win_last;
endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: directed and random checks of window_gen against a column-history model
module tb_window_gen;
  import hog_pkg::*;
  localparam int DW = 8;
  localparam int K = 3;
  localparam int W = 8;
  localparam int H = 5;
  localparam int ROWS = H - K + 1;
  localparam int FRAME = W * ROWS;
  localparam int WW = K * K * DW;
`ifdef WINDOW_BORDER_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam int WIN_PER_FRAME = SKIP ? ROWS * (W - K + 1) : FRAME;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  window_gen_if #(.DATA_WIDTH(DW), .KERNEL_WIDTH(K)) bus ();
  window_gen #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH(W),
    .IMG_HEIGHT(H),
    .KERNEL_WIDTH(K)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int n_cmp = 0;
  int n_err = 0;
  logic [K*DW-1:0] hist[$];
  int pos = 0;
  int taken = 0;
  logic exp_valid = 1'b0;
  logic exp_border = 1'b0;
  logic exp_last = 1'b0;
  logic [WW-1:0] exp_data = '0;
  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [K*DW-1:0] col_of(input int r, input int c);
    logic [K*DW-1:0] v;
    for (int i = 0; i < K; i++) v[i*DW +: DW] = {4'(r + i), 4'(c)};
    return v;
  endfunction
  // Window column j is the column accepted K-1-j accepts ago; zero before any accept since reset.
  task automatic model_accept(input logic [K*DW-1:0] d);
    logic border;
    int idx;
    hist.push_back(d);
    if (hist.size() > K) void'(hist.pop_front());
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) begin
        idx = hist.size() - K + j;
        exp_data[pix_lsb(i, j, K, DW) +: DW] = idx >= 0 ? hist[idx][i*DW +: DW] : '0;
      end
    border = (pos % W) < K - 1;
    exp_last = pos == FRAME - 1;
    pos = (pos + 1) % FRAME;
    exp_valid = !(SKIP && border);
    exp_border = border && !SKIP;
  endtask
  task automatic cyc(input logic v, input logic [K*DW-1:0] d, input logic r, output logic acc);
    bus.col_valid = v;
    bus.col_data = d;
    bus.win_ready = r;
    #1;
    chk("col_ready", WW'(bus.col_ready), WW'(!exp_valid || r));
    acc = v && (!exp_valid || r);
    if (bus.win_valid && r) taken++;
    @(posedge clk);
    if (acc) model_accept(d);
    else if (r) exp_valid = 1'b0;
    #1;
    chk("win_valid", WW'(bus.win_valid), WW'(exp_valid));
    if (exp_valid) begin
      chk("win_data", bus.win_data, exp_data);
      chk("border_flag", WW'(bus.border_flag), WW'(exp_border));
      chk("win_last", WW'(bus.win_last), WW'(exp_last));
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    bus.col_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", WW'(bus.win_valid), '0);
    chk("rst_data", bus.win_data, '0);
    chk("rst_border", WW'(bus.border_flag), '0);
    chk("rst_last", WW'(bus.win_last), '0);
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
    pos = 0;
    exp_valid = 1'b0;
    taken = 0;
  endtask
  task automatic stream_rows(input int r0, input int r1);
    logic a;
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < W; c++) cyc(1'b1, col_of(r, c), 1'b1, a);
  endtask
  initial begin
    logic a;
    int idx, n_acc, sent, cycles;
    logic [K*DW-1:0] d;
    bus.col_valid = 1'b0;
    bus.col_data = '0;
    bus.win_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("init_valid", WW'(bus.win_valid), '0);
    chk("init_data", bus.win_data, '0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) cyc(1'b1, col_of(0, c), 1'b1, a);
    do_reset();
    stream_rows(0, ROWS - 1);
    chk("last_flag", WW'(bus.win_last), WW'(1));
    cyc(1'b0, '0, 1'b1, a);
    chk("frame_windows", WW'(taken), WW'(WIN_PER_FRAME));
    cyc(1'b1, col_of(0, 0), 1'b1, a);
    chk("wrap_col0_pos", WW'(pos), WW'(1));
    cyc(1'b0, '0, 1'b1, a);
    idx = 1;
    n_acc = 0;
    for (int s = 0; s < 4; s++) begin
      cyc(1'b1, col_of(0, idx), 1'b0, a);
      if (a) begin
        idx++;
        n_acc++;
      end
    end
    chk("stall_accepts", WW'(n_acc), WW'(SKIP ? 2 : 1));
    chk("stall_ready", WW'(bus.col_ready), '0);
    while (idx < W) begin
      cyc(1'b1, col_of(0, idx), 1'b1, a);
      if (a) idx++;
    end
    stream_rows(1, ROWS - 1);
    chk("last_flag2", WW'(bus.win_last), WW'(1));
    do_reset();
    sent = 0;
    cycles = 0;
    d = K*DW'($urandom);
    while (sent < FRAME && cycles < 2000) begin
      cyc(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0), a);
      cycles++;
      if (a) begin
        sent++;
        d = K*DW'($urandom);
      end
    end
    chk("random_sent", WW'(sent), WW'(FRAME));
    for (int s = 0; s < 3; s++) cyc(1'b0, '0, 1'b1, a);
    chk("random_frame_windows", WW'(taken), WW'(WIN_PER_FRAME));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
